// File: rtl/lvt_sched_pkg.sv
// Shared constants and types for the LVT memory port scheduler.
// Latency: none, declarations only.
// Backpressure: n/a.
package lvt_sched_pkg;

    localparam int ADDR_W_DEF = 7;
    localparam int DATA_W_DEF = 32;

    // Width of the per-cycle write grant count (0, 1 or 2 grants).
    localparam int GCNT_W = 2;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        HELD  = 2'd3
    } state_t;

endpackage

// File: rtl/lvt_port_sched_rr_pick2.sv
// Round-robin two-of-N picker: first and second requesters at or after ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the picks become grants.
module rr_pick2 #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic          first_vld_o,
    output logic [IW-1:0] first_idx_o,
    output logic          second_vld_o,
    output logic [IW-1:0] second_idx_o
);

    int idx;

    // Scan N slots starting at ptr, taking the first two requesters encountered.
    always_comb begin
        first_vld_o  = 1'b0;
        first_idx_o  = '0;
        second_vld_o = 1'b0;
        second_idx_o = '0;
        idx          = 0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr_i) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (req_i[idx]) begin
                if (!first_vld_o) begin
                    first_vld_o = 1'b1;
                    first_idx_o = IW'(idx);
                end else if (!second_vld_o) begin
                    second_vld_o = 1'b1;
                    second_idx_o = IW'(idx);
                end
            end
        end
    end

endmodule

// File: rtl/lvt_port_sched.sv
// Schedules N write requesters onto two memory write ports and one read port, with RAW hazard and quiesce control.
// Latency: writes/reads reach the memory ports 1 cycle after handshake; read response 2 cycles after handshake.
// Backpressure: wreq_ready/rreq_ready are combinational; responses have no backpressure. Optional stats: LVT_PORT_SCHED_STATS_EN.
module lvt_port_sched
    import lvt_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        wreq_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] wreq_addr,
    input  logic [NUM_REQ*DATA_W-1:0] wreq_data,
    output logic [NUM_REQ-1:0]        wreq_ready,
    input  logic                      rreq_valid,
    input  logic [ADDR_W-1:0]         rreq_addr,
    output logic                      rreq_ready,
    output logic                      rrsp_valid,
    output logic [DATA_W-1:0]         rrsp_data,
    input  logic                      hold,
    output logic                      hold_ack,
    output logic                      wr0_en,
    output logic [ADDR_W-1:0]         wr0_addr,
    output logic [DATA_W-1:0]         wr0_data,
    output logic                      wr1_en,
    output logic [ADDR_W-1:0]         wr1_addr,
    output logic [DATA_W-1:0]         wr1_data,
    output logic                      rd0_en,
    output logic [ADDR_W-1:0]         rd0_addr,
    input  logic [DATA_W-1:0]         rd0_data
`ifdef LVT_PORT_SCHED_STATS_EN
    ,
    output logic [31:0]               stat_wr_grants,
    output logic [15:0]               stat_addr_conflicts,
    output logic [15:0]               stat_raw_stalls
`endif
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t              state_q, state_d;
    logic [IW-1:0]       ptr_q, ptr_d;

    logic                wr0_en_q, wr1_en_q, rd0_en_q, rsp_vld_q;
    logic [ADDR_W-1:0]   wr0_addr_q, wr1_addr_q, rd0_addr_q;
    logic [DATA_W-1:0]   wr0_data_q, wr1_data_q;

    logic                f_vld, s_vld;
    logic [IW-1:0]       f_idx, s_idx;
    logic [ADDR_W-1:0]   f_addr, s_addr;
    logic [DATA_W-1:0]   f_data, s_data;
    logic                grant_en, conflict, g0, g1;
    logic                reg_hit, grant_hit, raw_hit, rd_fire;

    function automatic logic [IW-1:0] rr_next(input logic [IW-1:0] idx);
        if (int'(idx) == NUM_REQ - 1) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

    rr_pick2 #(.N(NUM_REQ), .IW(IW)) u_pick (
        .req_i        (wreq_valid),
        .ptr_i        (ptr_q),
        .first_vld_o  (f_vld),
        .first_idx_o  (f_idx),
        .second_vld_o (s_vld),
        .second_idx_o (s_idx)
    );

    assign f_addr = wreq_addr[int'(f_idx)*ADDR_W +: ADDR_W];
    assign s_addr = wreq_addr[int'(s_idx)*ADDR_W +: ADDR_W];
    assign f_data = wreq_data[int'(f_idx)*DATA_W +: DATA_W];
    assign s_data = wreq_data[int'(s_idx)*DATA_W +: DATA_W];

    // hold seen in RUN already blocks grants, so a hold raised during INIT issues nothing.
    assign grant_en = (state_q == RUN) && !hold;
    assign conflict = f_vld && s_vld && (f_addr == s_addr);
    assign g0       = grant_en && f_vld;
    assign g1       = grant_en && s_vld && !conflict;

    // Read must not race a write being committed now or granted now to the same address.
    assign reg_hit   = (wr0_en_q && (wr0_addr_q == rreq_addr)) ||
                       (wr1_en_q && (wr1_addr_q == rreq_addr));
    assign grant_hit = (g0 && (f_addr == rreq_addr)) || (g1 && (s_addr == rreq_addr));
    assign raw_hit   = reg_hit || grant_hit;
    assign rreq_ready = grant_en && !raw_hit;
    assign rd_fire    = rreq_valid && rreq_ready;

    // Per-requester grant vector from the two picks.
    always_comb begin
        wreq_ready = '0;
        if (g0) begin
            wreq_ready[f_idx] = 1'b1;
        end
        if (g1) begin
            wreq_ready[s_idx] = 1'b1;
        end
    end

    // Pointer moves one past the last grant; a deferred same-address write becomes next head.
    always_comb begin
        ptr_d = ptr_q;
        if (g1) begin
            ptr_d = rr_next(s_idx);
        end else if (g0) begin
            ptr_d = conflict ? s_idx : rr_next(f_idx);
        end
    end

    // Quiesce FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            INIT:    state_d = RUN;
            RUN:     if (hold) state_d = DRAIN;
            DRAIN:   if (!rd0_en_q && !rsp_vld_q) state_d = HELD;
            HELD:    if (!hold) state_d = RUN;
            default: state_d = INIT;
        endcase
    end

    // State and round-robin pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= INIT;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Memory-side pipeline: grants and accepted reads registered once; response tracks rd0_en by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr0_en_q   <= 1'b0;
            wr1_en_q   <= 1'b0;
            rd0_en_q   <= 1'b0;
            rsp_vld_q  <= 1'b0;
            wr0_addr_q <= '0;
            wr1_addr_q <= '0;
            rd0_addr_q <= '0;
            wr0_data_q <= '0;
            wr1_data_q <= '0;
        end else begin
            wr0_en_q  <= g0;
            wr1_en_q  <= g1;
            rd0_en_q  <= rd_fire;
            rsp_vld_q <= rd0_en_q;
            if (g0) begin
                wr0_addr_q <= f_addr;
                wr0_data_q <= f_data;
            end
            if (g1) begin
                wr1_addr_q <= s_addr;
                wr1_data_q <= s_data;
            end
            if (rd_fire) begin
                rd0_addr_q <= rreq_addr;
            end
        end
    end

    assign wr0_en     = wr0_en_q;
    assign wr0_addr   = wr0_addr_q;
    assign wr0_data   = wr0_data_q;
    assign wr1_en     = wr1_en_q;
    assign wr1_addr   = wr1_addr_q;
    assign wr1_data   = wr1_data_q;
    assign rd0_en     = rd0_en_q;
    assign rd0_addr   = rd0_addr_q;
    assign rrsp_valid = rsp_vld_q;
    assign rrsp_data  = rsp_vld_q ? rd0_data : '0;
    assign hold_ack   = (state_q == HELD);

`ifdef LVT_PORT_SCHED_STATS_EN
    logic [31:0]       wr_grants_q;
    logic [15:0]       conflicts_q, raw_stalls_q;
    logic [GCNT_W-1:0] gcnt;
    logic [32:0]       wr_grants_sum;

    assign gcnt          = GCNT_W'(g0) + GCNT_W'(g1);
    assign wr_grants_sum = {1'b0, wr_grants_q} + 33'(gcnt);

    // Saturating event counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_grants_q  <= '0;
            conflicts_q  <= '0;
            raw_stalls_q <= '0;
        end else begin
            wr_grants_q <= wr_grants_sum[32] ? 32'hFFFF_FFFF : wr_grants_sum[31:0];
            if (grant_en && conflict && (conflicts_q != 16'hFFFF)) begin
                conflicts_q <= conflicts_q + 16'd1;
            end
            if (rreq_valid && grant_en && raw_hit && (raw_stalls_q != 16'hFFFF)) begin
                raw_stalls_q <= raw_stalls_q + 16'd1;
            end
        end
    end

    assign stat_wr_grants      = wr_grants_q;
    assign stat_addr_conflicts = conflicts_q;
    assign stat_raw_stalls     = raw_stalls_q;
`endif

endmodule

// File: tb/tb_lvt_port_sched.sv
// Directed bench for lvt_port_sched with a small behavioural memory on the port side.
// Latency: checks registered outputs one cycle and responses two cycles after handshake.
// Backpressure: drives inputs after the rising edge, samples on the falling edge.
module tb_lvt_port_sched;

    localparam int NR = 4;
    localparam int AW = 7;
    localparam int DW = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [NR-1:0]    wreq_valid;
    logic [NR*AW-1:0] wreq_addr;
    logic [NR*DW-1:0] wreq_data;
    logic [NR-1:0]    wreq_ready;
    logic             rreq_valid;
    logic [AW-1:0]    rreq_addr;
    logic             rreq_ready;
    logic             rrsp_valid;
    logic [DW-1:0]    rrsp_data;
    logic             hold;
    logic             hold_ack;
    logic             wr0_en, wr1_en, rd0_en;
    logic [AW-1:0]    wr0_addr, wr1_addr, rd0_addr;
    logic [DW-1:0]    wr0_data, wr1_data;
    logic [DW-1:0]    rd0_data = '0;
`ifdef LVT_PORT_SCHED_STATS_EN
    logic [31:0]      stat_wr_grants;
    logic [15:0]      stat_addr_conflicts;
    logic [15:0]      stat_raw_stalls;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    lvt_port_sched #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .wreq_valid (wreq_valid),
        .wreq_addr  (wreq_addr),
        .wreq_data  (wreq_data),
        .wreq_ready (wreq_ready),
        .rreq_valid (rreq_valid),
        .rreq_addr  (rreq_addr),
        .rreq_ready (rreq_ready),
        .rrsp_valid (rrsp_valid),
        .rrsp_data  (rrsp_data),
        .hold       (hold),
        .hold_ack   (hold_ack),
        .wr0_en     (wr0_en),
        .wr0_addr   (wr0_addr),
        .wr0_data   (wr0_data),
        .wr1_en     (wr1_en),
        .wr1_addr   (wr1_addr),
        .wr1_data   (wr1_data),
        .rd0_en     (rd0_en),
        .rd0_addr   (rd0_addr),
        .rd0_data   (rd0_data)
`ifdef LVT_PORT_SCHED_STATS_EN
        ,
        .stat_wr_grants      (stat_wr_grants),
        .stat_addr_conflicts (stat_addr_conflicts),
        .stat_raw_stalls     (stat_raw_stalls)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural memory: writes commit on the edge, read data lands one cycle after rd0_en.
    always @(posedge clk) begin
        if (wr0_en) mem[wr0_addr] <= wr0_data;
        if (wr1_en) mem[wr1_addr] <= wr1_data;
        if (rd0_en) rd0_data <= mem[rd0_addr];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic set_w(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wreq_addr[p*AW +: AW] = a;
        wreq_data[p*DW +: DW] = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] exp_rsp [3];
        exp_rsp[0] = 32'hA0; exp_rsp[1] = 32'hA1; exp_rsp[2] = 32'hA2;

        wreq_valid = '0; wreq_addr = '0; wreq_data = '0;
        rreq_valid = 1'b0; rreq_addr = '0; hold = 1'b0;
        #1 rst = 1'b1;
        cyc(); cyc(); smp();
        check("rst_wr0_en",   wr0_en, 0);
        check("rst_wr1_en",   wr1_en, 0);
        check("rst_rd0_en",   rd0_en, 0);
        check("rst_rrsp_vld", rrsp_valid, 0);
        check("rst_hold_ack", hold_ack, 0);
        check("rst_wrdy",     wreq_ready, 0);

        // INIT cycle: requests present but nothing granted.
        cyc(); rst = 1'b0;
        set_w(0, 7'h10, 32'hA0); set_w(1, 7'h11, 32'hA1);
        set_w(2, 7'h12, 32'hA2); set_w(3, 7'h13, 32'hA3);
        wreq_valid = 4'hF;
        smp();
        check("init_wrdy",  wreq_ready, 0);
        check("init_rrdy",  rreq_ready, 0);
        check("init_wr0en", wr0_en, 0);

        // Round-robin over four distinct writers.
        cyc(); smp();
        check("rr_g01_a", wreq_ready, 4'b0011);
        cyc(); smp();
        check("rr_g23",   wreq_ready, 4'b1100);
        check("rr_wr0en", wr0_en, 1);
        check("rr_wr0a",  wr0_addr, 7'h10);
        check("rr_wr0d",  wr0_data, 32'hA0);
        check("rr_wr1en", wr1_en, 1);
        check("rr_wr1a",  wr1_addr, 7'h11);
        check("rr_wr1d",  wr1_data, 32'hA1);
        cyc(); smp();
        check("rr_g01_b", wreq_ready, 4'b0011);
        check("rr_wr0a2", wr0_addr, 7'h12);
        check("rr_wr0d2", wr0_data, 32'hA2);
        check("rr_wr1a2", wr1_addr, 7'h13);
        check("rr_wr1d2", wr1_data, 32'hA3);
        cyc(); wreq_valid = '0; smp();
        check("rr_wr0a3", wr0_addr, 7'h10);
        check("rr_idle",  wreq_ready, 0);
        cyc(); smp();
        check("pulse_wr0", wr0_en, 0);
        check("pulse_wr1", wr1_en, 0);

        // Same-address pair: port 1 deferred one cycle.
        cyc();
        set_w(0, 7'h15, 32'hB0); set_w(1, 7'h15, 32'hB1);
        wreq_valid = 4'b0011;
        smp();
        check("cf_first", wreq_ready, 4'b0001);
        cyc(); wreq_valid = 4'b0010; smp();
        check("cf_defer", wreq_ready, 4'b0010);
        check("cf_wr0a",  wr0_addr, 7'h15);
        check("cf_wr0d",  wr0_data, 32'hB0);
        check("cf_wr1en", wr1_en, 0);
`ifdef LVT_PORT_SCHED_STATS_EN
        check("cf_stat",  stat_addr_conflicts, 1);
`endif
        cyc(); wreq_valid = '0; smp();
        check("cf_wr0d2", wr0_data, 32'hB1);

        // Read-after-write hazard on 0x2A.
        cyc();
        set_w(0, 7'h2A, 32'hDEADBEEF); wreq_valid = 4'b0001;
        rreq_valid = 1'b1; rreq_addr = 7'h2A;
        smp();
        check("raw_wgrant", wreq_ready, 4'b0001);
        check("raw_rrdy0",  rreq_ready, 0);
        cyc(); wreq_valid = '0; smp();
        check("raw_rrdy1",  rreq_ready, 0);
        cyc(); smp();
        check("raw_rrdy2",  rreq_ready, 1);
        cyc(); rreq_valid = 1'b0; smp();
        check("raw_rd0en",  rd0_en, 1);
        check("raw_rd0a",   rd0_addr, 7'h2A);
        check("raw_rsp_early", rrsp_valid, 0);
        cyc(); smp();
        check("raw_rspv",   rrsp_valid, 1);
        check("raw_rspd",   rrsp_data, 32'hDEADBEEF);
        check("raw_rd0off", rd0_en, 0);
        cyc(); smp();
        check("raw_rspoff", rrsp_valid, 0);

        // Back-to-back reads, one per cycle.
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (i < 3) begin
                rreq_valid = 1'b1; rreq_addr = AW'(7'h10 + i);
            end else begin
                rreq_valid = 1'b0;
            end
            smp();
            if (i < 3) check("tp_rrdy", rreq_ready, 1);
            if (i >= 2) begin
                check("tp_rspv", rrsp_valid, 1);
                check("tp_rspd", rrsp_data, exp_rsp[i-2]);
            end
        end

`ifdef LVT_PORT_SCHED_STATS_EN
        check("st_grants", stat_wr_grants, 9);
        check("st_raw",    stat_raw_stalls, 2);
`endif

        // Quiesce with a read in flight.
        cyc();
        set_w(0, 7'h40, 32'hC0); set_w(1, 7'h41, 32'hC1);
        set_w(2, 7'h42, 32'hC2); set_w(3, 7'h43, 32'hC3);
        rreq_valid = 1'b1; rreq_addr = 7'h13;
        smp();
        check("hd_rrdy", rreq_ready, 1);
        cyc(); rreq_valid = 1'b0; hold = 1'b1; wreq_valid = 4'hF; smp();
        check("hd_nogrant", wreq_ready, 0);
        check("hd_rd0en",   rd0_en, 1);
        cyc(); smp();
        check("hd_rspv",    rrsp_valid, 1);
        check("hd_rspd",    rrsp_data, 32'hA3);
        check("hd_ack_dr",  hold_ack, 0);
        check("hd_wrdy_dr", wreq_ready, 0);
        cyc(); smp();
        check("hd_ack_dr2", hold_ack, 0);
        cyc(); smp();
        check("hd_ack",     hold_ack, 1);
        check("hd_rrdy_h",  rreq_ready, 0);
        cyc(); hold = 1'b0; smp();
        check("hd_ack_rel", hold_ack, 1);
        check("hd_wrdy_h",  wreq_ready, 0);
        cyc(); smp();
        check("hd_resume",  wreq_ready, 4'b0110);
        check("hd_ack_off", hold_ack, 0);
        cyc(); wreq_valid = '0; smp();
        check("hd_wr0a", wr0_addr, 7'h41);
        check("hd_wr1a", wr1_addr, 7'h42);

        // Reset pulsed while a read is in flight.
        cyc(); rreq_valid = 1'b1; rreq_addr = 7'h40; smp();
        check("rs_rrdy", rreq_ready, 1);
        cyc(); rreq_valid = 1'b0; smp();
        check("rs_rd0en", rd0_en, 1);
        #1 rst = 1'b1;
        #1;
        check("rs_async_rd0en", rd0_en, 0);
        check("rs_async_rd0a",  rd0_addr, 0);
        check("rs_async_wr0a",  wr0_addr, 0);
        check("rs_async_wr0d",  wr0_data, 0);
        check("rs_async_wr1a",  wr1_addr, 0);
        check("rs_async_rspd",  rrsp_data, 0);
`ifdef LVT_PORT_SCHED_STATS_EN
        check("rs_async_stat",  stat_wr_grants, 0);
`endif
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (i == 1) rst = 1'b0;
            smp();
            check("rs_no_rsp", rrsp_valid, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
